sram_fifo_producer: RTL and testbench

- DMA-style stream producer that feeds a sync FIFO's write side from a single-port SRAM with 1-cycle read latency.
- On a start command it reads `length` consecutive words starting at `base_addr` and pushes them into the FIFO in address order.
- It throttles on the FIFO `full` flag and pulses `done` when the last word has been accepted.
- It sits between the activation/weight SRAM and the systolic-array input FIFOs.

---
 rtl/sram_fifo_producer_pkg.sv | 26 ++
 rtl/sram_fifo_producer_if.sv | 19 +
 rtl/sram_fifo_producer_skid_buf.sv | 51 +++++
 rtl/sram_fifo_producer.sv | 100 ++++++++++
 tb/tb_sram_fifo_producer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_fifo_producer_pkg.sv
//----------------------------------------------------------------------------
// Module  : tpu_stream_pkg
// Brief   : Shared types and helpers for the SRAM-to-FIFO stream producer.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package tpu_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int BUF_DEPTH = 2;

   // A length field must hold 0..2^addr_width inclusive.
   function automatic int len_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sram_fifo_producer_if.sv
//----------------------------------------------------------------------------
// Module  : sram_fifo_producer_if
// Brief   : Write-side bundle of a sync FIFO; master is the producer side.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface sram_fifo_producer_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  w_en;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  full;

   modport master (output w_en, output data_in, input full);
   modport slave  (input w_en, input data_in, output full);
endinterface

`default_nettype wire

// File: rtl/sram_fifo_producer_skid_buf.sv
//----------------------------------------------------------------------------
// Module  : producer_skid_buf
// Brief   : In-order buffer absorbing SRAM read data while the FIFO stalls.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module producer_skid_buf
   import tpu_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   input  wire logic                  push,
   input  wire logic                  pop,
   input  wire logic [DATA_WIDTH-1:0] din,
   output logic      [DATA_WIDTH-1:0] head,
   output logic      [CNT_W-1:0]      count
);

   logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
   logic [CNT_W-1:0]      r_count;
   logic [CNT_W-1:0]      w_wr_idx;

   // Entry 0 is always the head, so a pop shifts everything down one slot.
   assign w_wr_idx = r_count - CNT_W'(pop);
   assign head     = r_mem[0];
   assign count    = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BUF_DEPTH; i++) r_mem[i] <= '0;
         r_count <= '0;
      end else begin
         if (pop) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
         end
         if (push) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
               if (CNT_W'(i) == w_wr_idx) r_mem[i] <= din;
            end
         end
         r_count <= r_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

`default_nettype wire

// File: rtl/sram_fifo_producer.sv
//----------------------------------------------------------------------------
// Module  : sram_fifo_producer
// Brief   : Streams length words from a 1-cycle-latency SRAM into a sync FIFO.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module sram_fifo_producer
   import tpu_stream_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
) (
   input  wire logic                             clk,
   input  wire logic                             rst_n,
   input  wire logic                             start,
   input  wire logic [ADDR_WIDTH-1:0]            base_addr,
   input  wire logic [len_width(ADDR_WIDTH)-1:0] length,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  mem_re,
   output logic      [ADDR_WIDTH-1:0]            mem_addr,
   input  wire logic [DATA_WIDTH-1:0]            mem_rdata,
   sram_fifo_producer_if.master                  fifo
);

   localparam int LEN_W = len_width(ADDR_WIDTH);
   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   state_t                r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [LEN_W-1:0]      r_len, r_issued, r_written;
   logic                  r_inflight;
   logic [CNT_W-1:0]      w_count;
   logic [CNT_W-1:0]      w_occ;
   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_wen, w_last_read, w_last_write;

   producer_skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (r_inflight),
      .pop   (w_wen),
      .din   (mem_rdata),
      .head  (w_head),
      .count (w_count)
   );

   // Occupancy counts the in-flight read so full can rise without data loss.
   assign w_occ        = w_count + CNT_W'(r_inflight);
   assign w_wen        = (w_count != '0) && !fifo.full;
   assign w_last_read  = (r_issued + LEN_W'(1)) == r_len;
   assign w_last_write = (r_written + LEN_W'(1)) == r_len;

   assign mem_re       = (r_state == RUN) &&
                         ((w_occ < CNT_W'(BUF_DEPTH)) ||
                          ((w_occ == CNT_W'(BUF_DEPTH)) && w_wen));
   assign mem_addr     = r_base + r_issued[ADDR_WIDTH-1:0];
   assign fifo.w_en    = w_wen;
   assign fifo.data_in = w_head;
   assign busy         = (r_state != IDLE);
   assign done         = (r_state == DONE);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = (length == '0) ? DONE : RUN;
         RUN:     if (mem_re && w_last_read) w_state_nxt = DRAIN;
         DRAIN:   if (w_wen && w_last_write) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_base     <= '0;
         r_len      <= '0;
         r_issued   <= '0;
         r_written  <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_inflight <= mem_re;
         if (r_state == IDLE && start) begin
            r_base    <= base_addr;
            r_len     <= length;
            r_issued  <= '0;
            r_written <= '0;
         end else begin
            r_issued  <= r_issued + LEN_W'(mem_re);
            r_written <= r_written + LEN_W'(w_wen);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_sram_fifo_producer.sv
//----------------------------------------------------------------------------
// Module  : tb_sram_fifo_producer
// Brief   : Scoreboard bench for sram_fifo_producer with directed transfers.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_sram_fifo_producer;

   localparam int DW = 16;
   localparam int AW = 10;

   typedef struct {
      int v;
      int c;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW:0]   length = '0;
   logic          busy, done, mem_re;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rdata = '0;

   sram_fifo_producer_if #(.DATA_WIDTH(DW)) fifo ();

   sram_fifo_producer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .mem_re    (mem_re),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .fifo      (fifo)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   t0 = 0;
   int   rel;
   int   exp_done_rel = -1;
   bit   active = 1'b0;
   bit   done_seen = 1'b0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t q_re [$];
   exp_t q_wr [$];
   exp_t e;

   always @(posedge clk) cyc <= cyc + 1;

   // SRAM model: mem[a] = a + 0x100, one-cycle read latency.
   always @(posedge clk) if (mem_re) mem_rdata <= DW'(mem_addr) + 16'h0100;

   task automatic chk(input string name, input int act, input int exp_v);
      n_tests++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (rel cycle %0d)", name, act, exp_v, rel);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a read or a write.
   always @(negedge clk) begin
      rel = cyc - t0;
      if (!rst_n) begin
         chk("reset_outputs", int'({busy, done, mem_re, fifo.w_en}) + int'(mem_addr) + int'(fifo.data_in), 0);
      end else begin
         chk("busy", int'(busy), int'(active && rel >= 1 && rel <= exp_done_rel));
         if (fifo.w_en && fifo.full) chk("w_en_while_full", 1, 0);
         if (mem_re) begin
            if (q_re.size() == 0) chk("unexpected_mem_re", int'(mem_addr), -1);
            else begin
               e = q_re.pop_front();
               chk("mem_addr", int'(mem_addr), e.v);
               if (e.c >= 0) chk("mem_re_cycle", rel, e.c);
            end
         end
         if (fifo.w_en) begin
            if (q_wr.size() == 0) chk("unexpected_w_en", int'(fifo.data_in), -1);
            else begin
               e = q_wr.pop_front();
               chk("data_in", int'(fifo.data_in), e.v);
               if (e.c >= 0) chk("w_en_cycle", rel, e.c);
            end
         end
         if (done) begin
            chk("done_cycle", active ? rel : -1, exp_done_rel);
            done_seen = 1'b1;
         end
      end
   end

   task automatic push_re(input int a, input int c);
      exp_t x;
      x.v = a; x.c = c;
      q_re.push_back(x);
   endtask

   task automatic push_wr(input int d, input int c);
      exp_t x;
      x.v = d; x.c = c;
      q_wr.push_back(x);
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that samples start.
   task automatic issue(input int base, input int len, input int done_rel);
      t0           = cyc;
      exp_done_rel = done_rel;
      active       = 1'b1;
      done_seen    = 1'b0;
      base_addr    = AW'(base);
      length       = (AW + 1)'(len);
      start        = 1'b1;
      @(posedge clk); #1;
      start        = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40 && !done_seen; i++) @(posedge clk);
      #1;
      chk("done_seen", int'(done_seen), 1);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      fifo.full = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Basic transfer
      for (int i = 0; i < 4; i++) begin
         push_re(16'h010 + i, 1 + i);
         push_wr(16'h110 + i, 3 + i);
      end
      issue(16'h010, 4, 7);
      wait_done();

      // Backpressure: full high in cycles 4..6
      push_re(16'h010, 1); push_re(16'h011, 2); push_re(16'h012, 3); push_re(16'h013, 7);
      push_wr(16'h110, 3); push_wr(16'h111, 7); push_wr(16'h112, 8); push_wr(16'h113, 9);
      issue(16'h010, 4, 10);
      repeat (3) @(posedge clk);
      #1 fifo.full = 1'b1;
      repeat (3) @(posedge clk);
      #1 fifo.full = 1'b0;
      wait_done();

      // Zero length
      issue(16'h123, 0, 1);
      wait_done();

      // Address wrap
      push_re(16'h3FE, 1); push_re(16'h3FF, 2); push_re(16'h000, 3); push_re(16'h001, 4);
      push_wr(16'h4FE, 3); push_wr(16'h4FF, 4); push_wr(16'h100, 5); push_wr(16'h101, 6);
      issue(16'h3FE, 4, 7);
      wait_done();

      // Reset in cycle 4 of a length-8 transfer
      push_re(16'h040, 1); push_re(16'h041, 2); push_re(16'h042, 3);
      push_wr(16'h140, 3);
      issue(16'h040, 8, 11);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      active = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("reset_flush_re", q_re.size(), 0);
      chk("reset_flush_wr", q_wr.size(), 0);
      push_re(16'h020, 1); push_re(16'h021, 2);
      push_wr(16'h120, 3); push_wr(16'h121, 4);
      issue(16'h020, 2, 5);
      wait_done();

      // Start while busy is ignored
      for (int i = 0; i < 3; i++) begin
         push_re(16'h080 + i, 1 + i);
         push_wr(16'h180 + i, 3 + i);
      end
      issue(16'h080, 3, 6);
      repeat (2) @(posedge clk);
      #1;
      base_addr = AW'(16'h200);
      length    = (AW + 1)'(5);
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
      wait_done();
      repeat (8) @(posedge clk);
      #1;

      chk("final_re_queue", q_re.size(), 0);
      chk("final_wr_queue", q_wr.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
